alu_operand_sequencer: RTL and testbench

- Sequential front-end that drives the team's parameterised ALU: collects operand A, operand B and the 4-bit operation code from board switches and pushbuttons, then presents them on the ALU A/B/F inputs.
- After a settle interval it captures the ALU result and C/N/V/Z flags into output registers for display.
- Sits between the board I/O (switches, buttons) and the combinational ALU; the display logic consumes its registered outputs.

---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/btn_edge.sv | 22 ++
 rtl/alu_operand_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer: FSM state encoding,
// ALU opcodes, flag bit positions and the opcode validity check.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        READY   = 3'd3,
        EXEC    = 3'd4,
        DONE    = 3'd5
    } state_e;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_MOD = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;
    localparam logic [3:0] OP_SHL = 4'b1100;
    localparam logic [3:0] OP_SHR = 4'b1101;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    // Only the opcodes the ALU implements are accepted; everything else is an error.
    function automatic logic is_valid_op(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
                          OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR};
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced button level: one-cycle pulse on 0->1.
// The previous level resets to 0, so a button held through reset pulses once after release.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic pulse_o
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode from switches/buttons, drives the ALU, captures result and flags.
// Optional macro ALU_SEQ_CHAIN_EN: a load in DONE reuses the captured result as operand A.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int M             = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] sw_data,
    input  logic [3:0]   sw_op,
    input  logic         btn_load,
    input  logic         btn_exec,
    output logic [M-1:0] alu_a,
    output logic [M-1:0] alu_b,
    output logic [3:0]   alu_f,
    input  logic [M-1:0] alu_r,
    input  logic         alu_c,
    input  logic         alu_n,
    input  logic         alu_v,
    input  logic         alu_z,
    output logic [M-1:0] result_q,
    output logic [3:0]   flags_q,
    output logic [2:0]   state_q,
    output logic         done,
    output logic         err
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    logic load_p, exec_p;

    state_e       st_q, st_d;
    logic [M-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]   f_q, f_d, flg_q, flg_d, cnt_q, cnt_d;
    logic         done_q, done_d, err_q, err_d;

    btn_edge u_load_edge (
        .clk     (clk),
        .rst     (rst),
        .level_i (btn_load),
        .pulse_o (load_p)
    );

    btn_edge u_exec_edge (
        .clk     (clk),
        .rst     (rst),
        .level_i (btn_exec),
        .pulse_o (exec_p)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= WAIT_A;
            a_q    <= '0;
            b_q    <= '0;
            f_q    <= '0;
            res_q  <= '0;
            flg_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            a_q    <= a_d;
            b_q    <= b_d;
            f_q    <= f_d;
            res_q  <= res_d;
            flg_q  <= flg_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        a_d    = a_q;
        b_d    = b_q;
        f_d    = f_q;
        res_d  = res_q;
        flg_d  = flg_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        err_d  = err_q;
        case (st_q)
            WAIT_A: begin
                if (load_p) begin
                    a_d   = sw_data;
                    err_d = 1'b0;
                    st_d  = WAIT_B;
                end
            end
            WAIT_B: begin
                if (load_p) begin
                    b_d  = sw_data;
                    st_d = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (load_p) begin
                    if (is_valid_op(sw_op)) begin
                        f_d  = sw_op;
                        st_d = READY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            READY: begin
                if (exec_p) begin
                    cnt_d = CNT_INIT;
                    st_d  = EXEC;
                end else if (load_p) begin
                    st_d = WAIT_OP;
                end
            end
            EXEC: begin
                // Buttons are ignored here; operands stay frozen while the ALU settles.
                if (cnt_q == 4'd0) begin
                    if ((f_q == OP_DIV || f_q == OP_MOD) && b_q == '0) begin
                        res_d = '1;
                        flg_d = '0;
                        err_d = 1'b1;
                    end else begin
                        res_d         = alu_r;
                        flg_d[FLAG_C] = alu_c;
                        flg_d[FLAG_N] = alu_n;
                        flg_d[FLAG_V] = alu_v;
                        flg_d[FLAG_Z] = alu_z;
                    end
                    done_d = 1'b1;
                    st_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (exec_p) begin
                    cnt_d = CNT_INIT;
                    st_d  = EXEC;
                end else if (load_p) begin
`ifdef ALU_SEQ_CHAIN_EN
                    a_d = res_q;
`else
                    a_d = sw_data;
`endif
                    err_d = 1'b0;
                    st_d  = WAIT_B;
                end
            end
            default: begin
                st_d = WAIT_A;
            end
        endcase
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_f    = f_q;
    assign result_q = res_q;
    assign flags_q  = flg_q;
    assign state_q  = st_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with a behavioural 4-bit ALU attached.
// Stimulus pushes expectations; a negedge monitor is the only place comparisons happen.
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sw_data = '0, sw_op = '0;
    logic       btn_load = 1'b0, btn_exec = 1'b0;
    logic [3:0] alu_a, alu_b, alu_f, alu_r, result_q, flags_q;
    logic       alu_c, alu_n, alu_v, alu_z, done, err;
    logic [2:0] state_q;

`ifdef ALU_SEQ_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_operand_sequencer #(.M(4), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .sw_data(sw_data), .sw_op(sw_op),
        .btn_load(btn_load), .btn_exec(btn_exec),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_r(alu_r), .alu_c(alu_c), .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z),
        .result_q(result_q), .flags_q(flags_q), .state_q(state_q),
        .done(done), .err(err)
    );

    // Behavioural ALU: returns {C,N,V,Z,R}.
    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] f);
        logic [4:0] s;
        logic [7:0] p;
        logic [3:0] r;
        logic c, v;
        r = '0; c = 1'b0; v = 1'b0;
        case (f)
            4'b0000: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
                           v = (a[3] == b[3]) && (r[3] != a[3]); end
            4'b0001: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4];
                           v = (a[3] != b[3]) && (r[3] != a[3]); end
            4'b0100: begin p = a * b; r = p[3:0]; c = |p[7:4]; end
            4'b0101: r = (b != 0) ? a / b : 4'd0;
            4'b0110: r = (b != 0) ? a % b : 4'd0;
            4'b1000: r = a & b;
            4'b1001: r = a | b;
            4'b1010: r = a ^ b;
            4'b1100: r = a << b[1:0];
            4'b1101: r = a >> b[1:0];
            default: r = 4'd0;
        endcase
        return {c, r[3], v, (r == 4'd0), r};
    endfunction

    always_comb {alu_c, alu_n, alu_v, alu_z, alu_r} = alu_ref(alu_a, alu_b, alu_f);

    function automatic bit op_ok(input logic [3:0] op);
        return !(op == 4'd2 || op == 4'd3 || op == 4'd7 || op == 4'd11 ||
                 op == 4'd14 || op == 4'd15);
    endfunction

    typedef enum {K_STATE, K_ALUA, K_ALUB, K_ALUF, K_ERR, K_RES, K_FLG, K_DONE,
                  K_LAT, K_TIMEOUT} kind_e;
    typedef struct {
        kind_e kind;
        int    exp;
        int    act;
        string name;
    } chk_t;

    chk_t       cq[$];
    logic [8:0] sbq[$];          // {result, flags, err} expected at each done pulse
    bit         finishing = 1'b0;
    int         tests = 0;
    int         fails = 0;

    // ---------------- monitor: sole comparator ----------------
    chk_t       c;
    logic [8:0] e;
    int         act;
    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done: done=1 with no pending execution");
            end else begin
                e = sbq.pop_front();
                tests++;
                if (result_q !== e[8:5]) begin
                    fails++;
                    $display("FAIL done_result: got %b expected %b", result_q, e[8:5]);
                end
                tests++;
                if (flags_q !== e[4:1]) begin
                    fails++;
                    $display("FAIL done_flags: got %b expected %b", flags_q, e[4:1]);
                end
                tests++;
                if (err !== e[0]) begin
                    fails++;
                    $display("FAIL done_err: got %b expected %b", err, e[0]);
                end
                $display("[TB] done: result=%b flags=%b err=%b", result_q, flags_q, err);
            end
        end
        while (cq.size() > 0) begin
            c = cq.pop_front();
            case (c.kind)
                K_STATE: act = int'(state_q);
                K_ALUA:  act = int'(alu_a);
                K_ALUB:  act = int'(alu_b);
                K_ALUF:  act = int'(alu_f);
                K_ERR:   act = int'(err);
                K_RES:   act = int'(result_q);
                K_FLG:   act = int'(flags_q);
                K_DONE:  act = int'(done);
                default: act = c.act;
            endcase
            tests++;
            if (act != c.exp) begin
                fails++;
                $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
            end
        end
        if (finishing) begin
            tests++;
            if (sbq.size() != 0) begin
                fails++;
                $display("FAIL pending_results: got %0d outstanding expected 0", sbq.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model state ----------------
    logic [3:0] ma = '0, mb = '0, mf = '0, mres = '0;
    logic       merr = 1'b0, mdone = 1'b0;

    task automatic expect_chk(input kind_e k, input int ex, input string n, input int a = 0);
        cq.push_back('{kind: k, exp: ex, act: a, name: n});
    endtask

    task automatic press(input logic ld, input logic ex, input logic [3:0] d,
                         input logic [3:0] op);
        @(posedge clk); #1;
        sw_data = d; sw_op = op; btn_load = ld; btn_exec = ex;
        @(posedge clk); #1;
        btn_load = 1'b0; btn_exec = 1'b0;
    endtask

    task automatic load_a(input logic [3:0] d);
        press(1'b1, 1'b0, d, 4'd0);
        ma    = (CHAIN && mdone) ? mres : d;
        merr  = 1'b0;
        mdone = 1'b0;
        $display("[TB] load A sw=%b -> expect alu_a=%b", d, ma);
        expect_chk(K_ALUA, ma, "load_a_value");
        expect_chk(K_STATE, 1, "load_a_state");
        expect_chk(K_ERR, 0, "load_a_err_clear");
    endtask

    task automatic load_b(input logic [3:0] d);
        press(1'b1, 1'b0, d, 4'd0);
        mb = d;
        $display("[TB] load B sw=%b", d);
        expect_chk(K_ALUB, mb, "load_b_value");
        expect_chk(K_STATE, 2, "load_b_state");
    endtask

    task automatic load_op(input logic [3:0] op);
        press(1'b1, 1'b0, 4'd0, op);
        if (op_ok(op)) begin
            mf = op;
            expect_chk(K_STATE, 3, "load_op_state");
        end else begin
            merr = 1'b1;
            expect_chk(K_STATE, 2, "bad_op_state");
        end
        $display("[TB] load op %b (valid=%0d)", op, op_ok(op));
        expect_chk(K_ALUF, mf, "load_op_alu_f");
        expect_chk(K_ERR, merr, "load_op_err");
    endtask

    task automatic back_to_op();
        press(1'b1, 1'b0, 4'd0, 4'd0);
        $display("[TB] load in READY -> back to WAIT_OP");
        expect_chk(K_STATE, 2, "ready_load_state");
    endtask

    task automatic do_exec(input logic with_load);
        logic [7:0] rr;
        logic [3:0] rres, rflg;
        int n;
        rr = alu_ref(ma, mb, mf);
        rres = rr[3:0];
        rflg = rr[7:4];
        if ((mf == 4'b0101 || mf == 4'b0110) && mb == 4'd0) begin
            rres = 4'hF; rflg = 4'h0; merr = 1'b1;
        end
        mres = rres;
        sbq.push_back({rres, rflg, merr});
        press(with_load, 1'b1, 4'($urandom_range(0, 15)), ~mf);
        $display("[TB] exec a=%b b=%b f=%b load=%0d -> expect r=%b flags=%b err=%b",
                 ma, mb, mf, with_load, rres, rflg, merr);
        expect_chk(K_STATE, 4, "exec_state");
        expect_chk(K_ALUF, mf, "exec_alu_f_held");
        n = 1;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) expect_chk(K_TIMEOUT, 0, "done_timeout", 1);
        else expect_chk(K_LAT, 3, "exec_to_done_latency", n);
        @(posedge clk); #1;
        expect_chk(K_DONE, 0, "done_single_cycle");
        expect_chk(K_STATE, 5, "done_state");
        mdone = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] op;
        repeat (3) @(posedge clk);
        #1;
        expect_chk(K_STATE, 0, "reset_state");
        expect_chk(K_ALUA, 0, "reset_alu_a");
        expect_chk(K_RES, 0, "reset_result");
        expect_chk(K_FLG, 0, "reset_flags");
        expect_chk(K_DONE, 0, "reset_done");
        expect_chk(K_ERR, 0, "reset_err");
        @(posedge clk); #1;
        rst = 1'b1;

        // 0101 + 0011: overflow into negative
        load_a(4'b0101); load_b(4'b0011); load_op(4'b0000); do_exec(1'b0);
        expect_chk(K_RES, 8, "add_result");
        expect_chk(K_FLG, 4'b0110, "add_flags");

        // divide by zero
        load_a(4'b0110); load_b(4'b0000); load_op(4'b0101); do_exec(1'b0);
        expect_chk(K_ERR, 1, "div0_err");
        load_a(4'b0001);

        // invalid opcode, then valid; simultaneous load+exec in READY
        load_b(4'b0111); load_op(4'b0011); load_op(4'b1010); do_exec(1'b1);

        // reset in the middle of EXEC
        load_a(4'b0011); load_b(4'b0100); load_op(4'b0100);
        @(posedge clk); #1; btn_exec = 1'b1;
        @(posedge clk); #1; btn_exec = 1'b0;
        #2 rst = 1'b0;
        #1;
        $display("[TB] reset asserted during EXEC");
        expect_chk(K_STATE, 0, "midexec_rst_state");
        expect_chk(K_ALUA, 0, "midexec_rst_alu_a");
        expect_chk(K_ALUB, 0, "midexec_rst_alu_b");
        expect_chk(K_ALUF, 0, "midexec_rst_alu_f");
        expect_chk(K_RES, 0, "midexec_rst_result");
        expect_chk(K_FLG, 0, "midexec_rst_flags");
        expect_chk(K_DONE, 0, "midexec_rst_done");
        expect_chk(K_ERR, 0, "midexec_rst_err");
        @(posedge clk); #1;
        rst = 1'b1;
        ma = '0; mb = '0; mf = '0; mres = '0; merr = 1'b0; mdone = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        expect_chk(K_STATE, 0, "after_rst_state");

        // 0010 + 0011, then a load in DONE (chain mode takes the result)
        load_a(4'b0010); load_b(4'b0011); load_op(4'b0000); do_exec(1'b0);
        expect_chk(K_RES, 5, "chain_sum_result");
        load_a(4'b1001);
        load_b(4'($urandom_range(0, 15))); load_op(4'b0001); do_exec(1'b0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_exec(1'b0);
            end else begin
                load_a(4'($urandom_range(0, 15)));
                load_b(($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15)));
                op = 4'($urandom_range(0, 15));
                load_op(op);
                while (!op_ok(op)) begin
                    op = 4'($urandom_range(0, 15));
                    load_op(op);
                end
                if ($urandom_range(0, 3) == 0) begin
                    back_to_op();
                    op = 4'($urandom_range(0, 15));
                    while (!op_ok(op)) op = 4'($urandom_range(0, 15));
                    load_op(op);
                end
                do_exec($urandom_range(0, 4) == 0);
            end
        end

        repeat (4) @(posedge clk);
        #1;
        finishing = 1'b1;
    end

endmodule
